// File: rtl/period_meter.sv
// period_meter: single-shot measurement of one period of a slow asynchronous input, in clock_in cycles.
// Define PERIOD_METER_HIGH_TIME_EN to add the high_cnt output (length of the high phase).
module period_meter #(
  parameter int CNT_W       = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock_in,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] period,
  output logic             overflow
`ifdef PERIOD_METER_HIGH_TIME_EN
  ,
  output logic [CNT_W-1:0] high_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, ARM, COUNT, DONE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_sync;
  logic                   s_prev;
  logic                   rise;
  logic [CNT_W-1:0]       cnt;

  assign s_sync = sync_q[SYNC_STAGES-1];
  assign rise   = s_sync & ~s_prev;

  always_ff @(posedge clock_in or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      s_prev <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_prev <= s_sync;
    end
  end

  always_ff @(posedge clock_in or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      valid    <= 1'b0;
      period   <= '0;
      overflow <= 1'b0;
      cnt      <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= ARM;
            busy  <= 1'b1;
          end
        end
        ARM: begin
          if (rise) begin
            cnt   <= CNT_W'(1);
            state <= COUNT;
          end
        end
        COUNT: begin
          // A rise on the saturation cycle still yields a normal result.
          if (rise) begin
            period   <= cnt;
            overflow <= 1'b0;
            valid    <= 1'b1;
            state    <= DONE;
          end else if (&cnt) begin
            period   <= '1;
            overflow <= 1'b1;
            valid    <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PERIOD_METER_HIGH_TIME_EN
  logic [CNT_W-1:0] hcnt;

  // After the first fall s_sync stays low until the next rise, which ends
  // COUNT, so gating on s_sync alone freezes hcnt at the falling edge.
  always_ff @(posedge clock_in or negedge rst) begin
    if (!rst) begin
      hcnt     <= '0;
      high_cnt <= '0;
    end else begin
      if (state == ARM && rise)
        hcnt <= CNT_W'(1);
      else if (state == COUNT && s_sync && !(&hcnt))
        hcnt <= hcnt + CNT_W'(1);
      if (state == COUNT && (rise || (&cnt)))
        high_cnt <= hcnt;
    end
  end
`endif

endmodule
